// File: rtl/decoder.sv
// decoder: combinational MIPS instruction decoder with a sticky illegal-instruction flag.
// Unrecognised encodings drive only `illegal`; every other output stays at its zero default.
module decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    output logic        lb,
    output logic        lbu,
    output logic        lh,
    output logic        lhu,
    output logic        lw,
    output logic        sb,
    output logic        sh,
    output logic        sw,
    output logic        DMWE,
    output logic        RFWE,
    output logic [1:0]  A3Sel,
    output logic [1:0]  WDSel,
    output logic        ALUSrcB,
    output logic [1:0]  EXTOp,
    output logic [3:0]  ALUOp,
    output logic [2:0]  BrType,
    output logic        j,
    output logic        jal,
    output logic        jr,
    output logic        jalr,
    output logic [3:0]  MDUOp,
    output logic        illegal,
    output logic        illegal_seen
);
    logic [5:0] w_op, w_funct;
    logic [4:0] w_rt, w_rd, w_dst;
    logic       w_wr, w_unused;
    logic       r_illegal_seen;

    assign w_op     = Instr[31:26];
    assign w_rt     = Instr[20:16];
    assign w_rd     = Instr[15:11];
    assign w_funct  = Instr[5:0];
    assign w_unused = ^{Instr[25:21], Instr[10:6]};

    always_comb begin
        {lb, lbu, lh, lhu, lw, sb, sh, sw} = '0;
        {j, jal, jr, jalr, illegal, ALUSrcB, w_wr} = '0;
        A3Sel  = 2'b00;
        WDSel  = 2'b00;
        EXTOp  = 2'b00;
        ALUOp  = 4'd0;
        BrType = 3'd0;
        MDUOp  = 4'd0;
        case (w_op)
            6'b000000: begin
                A3Sel = 2'b01;
                w_wr  = 1'b1;
                case (w_funct)
                    6'b100000, 6'b100001: ALUOp = 4'd0;
                    6'b100010, 6'b100011: ALUOp = 4'd1;
                    6'b100100: ALUOp = 4'd2;
                    6'b100101: ALUOp = 4'd3;
                    6'b100110: ALUOp = 4'd4;
                    6'b100111: ALUOp = 4'd5;
                    6'b101010: ALUOp = 4'd6;
                    6'b101011: ALUOp = 4'd7;
                    6'b000000: ALUOp = 4'd8;
                    6'b000010: ALUOp = 4'd9;
                    6'b000011: ALUOp = 4'd10;
                    6'b000100: ALUOp = 4'd11;
                    6'b000110: ALUOp = 4'd12;
                    6'b000111: ALUOp = 4'd13;
                    6'b001000: begin jr = 1'b1; A3Sel = 2'b00; w_wr = 1'b0; end
                    6'b001001: begin jalr = 1'b1; WDSel = 2'b10; end
                    6'b010000: begin MDUOp = 4'd7; WDSel = 2'b11; end
                    6'b010010: begin MDUOp = 4'd8; WDSel = 2'b11; end
                    6'b010001: begin MDUOp = 4'd5; A3Sel = 2'b00; w_wr = 1'b0; end
                    6'b010011: begin MDUOp = 4'd6; A3Sel = 2'b00; w_wr = 1'b0; end
                    // mult, multu, div, divu map to MDUOp 1..4 in funct order
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                        MDUOp = 4'd1 + {2'b00, w_funct[1:0]};
                        A3Sel = 2'b00;
                        w_wr  = 1'b0;
                    end
                    default: begin illegal = 1'b1; A3Sel = 2'b00; w_wr = 1'b0; end
                endcase
            end
            6'b000001: begin
                case (w_rt)
                    5'd0:    BrType = 3'd5;
                    5'd1:    BrType = 3'd6;
                    default: illegal = 1'b1;
                endcase
            end
            6'b000100: BrType = 3'd1;
            6'b000101: BrType = 3'd2;
            6'b000110: BrType = 3'd3;
            6'b000111: BrType = 3'd4;
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                w_wr    = 1'b1;
                ALUSrcB = 1'b1;
                EXTOp   = (w_op[2:0] == 3'b111) ? 2'b10 : w_op[2] ? 2'b00 : 2'b01;
                ALUOp   = w_op[2] ? ((w_op[1:0] == 2'b00) ? 4'd2 : (w_op[1:0] == 2'b10) ? 4'd4 : 4'd3)
                                  : (w_op[1] ? {3'b011, w_op[0]} : 4'd0);
            end
            6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
                lb      = (w_op == 6'b100000);
                lh      = (w_op == 6'b100001);
                lw      = (w_op == 6'b100011);
                lbu     = (w_op == 6'b100100);
                lhu     = (w_op == 6'b100101);
                w_wr    = 1'b1;
                ALUSrcB = 1'b1;
                EXTOp   = 2'b01;
                WDSel   = 2'b01;
            end
            6'b101000, 6'b101001, 6'b101011: begin
                sb      = (w_op == 6'b101000);
                sh      = (w_op == 6'b101001);
                sw      = (w_op == 6'b101011);
                ALUSrcB = 1'b1;
                EXTOp   = 2'b01;
            end
            6'b000010: j = 1'b1;
            6'b000011: begin jal = 1'b1; w_wr = 1'b1; A3Sel = 2'b10; WDSel = 2'b10; end
            default: illegal = 1'b1;
        endcase
    end

    // Writes to $0 are suppressed so nop and friends never touch the register file.
    assign w_dst = (A3Sel == 2'b01) ? w_rd : (A3Sel == 2'b10) ? 5'd31 : w_rt;
    assign RFWE  = w_wr & (|w_dst);
    assign DMWE  = sb | sh | sw;

    always_ff @(posedge clk) begin
        if (reset)
            r_illegal_seen <= 1'b0;
        else if (illegal)
            r_illegal_seen <= 1'b1;
    end

    assign illegal_seen = r_illegal_seen;
endmodule

// File: tb/tb_decoder.sv
// tb_decoder: randomized scoreboard bench for the decoder against a mnemonic-level reference model.
module tb_decoder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Instr = 32'h0;
    logic        lb, lbu, lh, lhu, lw, sb, sh, sw, DMWE, RFWE, ALUSrcB;
    logic [1:0]  A3Sel, WDSel, EXTOp;
    logic [3:0]  ALUOp, MDUOp;
    logic [2:0]  BrType;
    logic        j, jal, jr, jalr, illegal, illegal_seen;

    decoder dut (
        .clk(clk), .reset(reset), .Instr(Instr),
        .lb(lb), .lbu(lbu), .lh(lh), .lhu(lhu), .lw(lw),
        .sb(sb), .sh(sh), .sw(sw), .DMWE(DMWE), .RFWE(RFWE),
        .A3Sel(A3Sel), .WDSel(WDSel), .ALUSrcB(ALUSrcB), .EXTOp(EXTOp),
        .ALUOp(ALUOp), .BrType(BrType), .j(j), .jal(jal), .jr(jr), .jalr(jalr),
        .MDUOp(MDUOp), .illegal(illegal), .illegal_seen(illegal_seen)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic lb, lbu, lh, lhu, lw, sb, sh, sw, DMWE, RFWE;
        logic [1:0] A3Sel, WDSel;
        logic ALUSrcB;
        logic [1:0] EXTOp;
        logic [3:0] ALUOp;
        logic [2:0] BrType;
        logic j, jal, jr, jalr;
        logic [3:0] MDUOp;
        logic illegal;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        exp_t        o;
        logic        seen;
    } item_t;

    item_t      q[$];
    string      rn[64];
    string      on[64];
    string      alu_l[14] = '{"add", "sub", "and", "or", "xor", "nor", "slt", "sltu",
                              "sll", "srl", "sra", "sllv", "srlv", "srav"};
    string      br_l[7]   = '{"", "beq", "bne", "blez", "bgtz", "bltz", "bgez"};
    string      mdu_l[9]  = '{"", "mult", "multu", "div", "divu", "mthi", "mtlo", "mfhi", "mflo"};
    logic [5:0] legal_ops[$];
    logic [5:0] legal_fn[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic       m_seen = 1'b0;

    function automatic string mnem(logic [31:0] ins);
        if (ins[31:26] == 6'd0) return rn[ins[5:0]];
        if (ins[31:26] == 6'd1) return (ins[20:16] == 5'd0) ? "bltz" : (ins[20:16] == 5'd1) ? "bgez" : "";
        return on[ins[31:26]];
    endfunction

    function automatic string base(string m);
        case (m)
            "addu", "addi", "addiu": return "add";
            "subu":                  return "sub";
            "slti":                  return "slt";
            "sltiu":                 return "sltu";
            "andi":                  return "and";
            "ori", "lui":            return "or";
            "xori":                  return "xor";
            default:                 return m;
        endcase
    endfunction

    function automatic int alu_code(string m);
        for (int i = 0; i < 14; i++) if (alu_l[i] == m) return i;
        return 0;
    endfunction

    function automatic int br_code(string m);
        for (int i = 1; i < 7; i++) if (br_l[i] == m) return i;
        return 0;
    endfunction

    function automatic int mdu_code(string m);
        for (int i = 1; i < 9; i++) if (mdu_l[i] == m) return i;
        return 0;
    endfunction

    function automatic exp_t model(logic [31:0] ins);
        exp_t       e = '0;
        string      m = mnem(ins);
        logic       wr = 1'b0;
        logic [4:0] dst;
        case (m)
            "": e.illegal = 1'b1;
            "add", "addu", "sub", "subu", "and", "or", "xor", "nor", "slt", "sltu",
            "sll", "srl", "sra", "sllv", "srlv", "srav": begin
                wr = 1'b1; e.A3Sel = 2'd1; e.ALUOp = 4'(alu_code(base(m)));
            end
            "addi", "addiu", "slti", "sltiu", "andi", "ori", "xori", "lui": begin
                wr = 1'b1; e.ALUSrcB = 1'b1; e.ALUOp = 4'(alu_code(base(m)));
                e.EXTOp = (m == "andi" || m == "ori" || m == "xori") ? 2'd0 : (m == "lui") ? 2'd2 : 2'd1;
            end
            "lb", "lbu", "lh", "lhu", "lw": begin
                wr = 1'b1; e.ALUSrcB = 1'b1; e.EXTOp = 2'd1; e.WDSel = 2'd1;
            end
            "sb", "sh", "sw": begin e.ALUSrcB = 1'b1; e.EXTOp = 2'd1; e.DMWE = 1'b1; end
            "jal":            begin wr = 1'b1; e.A3Sel = 2'd2; e.WDSel = 2'd2; end
            "jalr":           begin wr = 1'b1; e.A3Sel = 2'd1; e.WDSel = 2'd2; end
            "mfhi", "mflo":   begin wr = 1'b1; e.A3Sel = 2'd1; e.WDSel = 2'd3; end
            default: ;
        endcase
        e.lb = (m == "lb");  e.lbu = (m == "lbu"); e.lh = (m == "lh");
        e.lhu = (m == "lhu"); e.lw = (m == "lw");
        e.sb = (m == "sb");  e.sh = (m == "sh");  e.sw = (m == "sw");
        e.j = (m == "j"); e.jal = (m == "jal"); e.jr = (m == "jr"); e.jalr = (m == "jalr");
        e.BrType = 3'(br_code(m));
        e.MDUOp  = 4'(mdu_code(m));
        dst = (e.A3Sel == 2'd1) ? ins[15:11] : (e.A3Sel == 2'd2) ? 5'd31 : ins[20:16];
        e.RFWE = wr && (dst != 5'd0);
        return e;
    endfunction

    task automatic issue(input logic [31:0] ins, input logic rst);
        exp_t prev;
        @(posedge clk);
        prev = model(Instr);
        m_seen = reset ? 1'b0 : (m_seen | prev.illegal);
        #1;
        Instr = ins;
        reset = rst;
        q.push_back('{ins, model(ins), m_seen});
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] r = $urandom;
        if ($urandom_range(0, 3) == 0) return r;
        r[31:26] = legal_ops[$urandom_range(0, legal_ops.size() - 1)];
        if (r[31:26] == 6'd0) r[5:0] = legal_fn[$urandom_range(0, legal_fn.size() - 1)];
        if (r[31:26] == 6'd1) r[20:16] = 5'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) r[20:11] = '0;
        return r;
    endfunction

    always @(negedge clk) begin
        item_t it;
        exp_t  a;
        if (q.size() != 0) begin
            it = q.pop_front();
            a = {lb, lbu, lh, lhu, lw, sb, sh, sw, DMWE, RFWE, A3Sel, WDSel, ALUSrcB, EXTOp,
                 ALUOp, BrType, j, jal, jr, jalr, MDUOp, illegal};
            n_chk++;
            if (a !== it.o) begin
                n_fail++;
                $display("FAIL decode ins=%h got=%h exp=%h", it.ins, a, it.o);
            end
            n_chk++;
            if (illegal_seen !== it.seen) begin
                n_fail++;
                $display("FAIL illegal_seen ins=%h got=%b exp=%b", it.ins, illegal_seen, it.seen);
            end
        end
    end

    initial begin
        rn[6'h20] = "add";  rn[6'h21] = "addu"; rn[6'h22] = "sub";   rn[6'h23] = "subu";
        rn[6'h24] = "and";  rn[6'h25] = "or";   rn[6'h26] = "xor";   rn[6'h27] = "nor";
        rn[6'h2a] = "slt";  rn[6'h2b] = "sltu"; rn[6'h00] = "sll";   rn[6'h02] = "srl";
        rn[6'h03] = "sra";  rn[6'h04] = "sllv"; rn[6'h06] = "srlv";  rn[6'h07] = "srav";
        rn[6'h08] = "jr";   rn[6'h09] = "jalr"; rn[6'h10] = "mfhi";  rn[6'h11] = "mthi";
        rn[6'h12] = "mflo"; rn[6'h13] = "mtlo"; rn[6'h18] = "mult";  rn[6'h19] = "multu";
        rn[6'h1a] = "div";  rn[6'h1b] = "divu";
        on[6'h02] = "j";    on[6'h03] = "jal";  on[6'h04] = "beq";   on[6'h05] = "bne";
        on[6'h06] = "blez"; on[6'h07] = "bgtz"; on[6'h08] = "addi";  on[6'h09] = "addiu";
        on[6'h0a] = "slti"; on[6'h0b] = "sltiu"; on[6'h0c] = "andi"; on[6'h0d] = "ori";
        on[6'h0e] = "xori"; on[6'h0f] = "lui";  on[6'h20] = "lb";    on[6'h21] = "lh";
        on[6'h23] = "lw";   on[6'h24] = "lbu";  on[6'h25] = "lhu";   on[6'h28] = "sb";
        on[6'h29] = "sh";   on[6'h2b] = "sw";
        legal_ops.push_back(6'd0);
        legal_ops.push_back(6'd1);
        for (int i = 0; i < 64; i++) begin
            if (on[i] != "") legal_ops.push_back(6'(i));
            if (rn[i] != "") legal_fn.push_back(6'(i));
        end
        issue(32'h0000_0000, 1'b1);
        issue(32'h0000_0000, 1'b0);
        issue(32'hAFA8_0004, 1'b0);
        issue(32'h8109_0003, 1'b0);
        issue(32'h9109_0003, 1'b0);
        issue(32'h8509_0003, 1'b0);
        issue(32'h9509_0003, 1'b0);
        issue(32'h8D09_0003, 1'b0);
        issue(32'h0C00_0010, 1'b0);
        issue(32'h03E0_0008, 1'b0);
        issue(32'h0000_0000, 1'b0);
        issue(32'h0405_0000, 1'b0);
        issue(32'h0000_0000, 1'b1);
        issue(32'h0000_0000, 1'b0);
        issue(32'hFC00_0000, 1'b0);
        issue(32'h0000_5010, 1'b0);
        issue(32'h0109_001A, 1'b0);
        issue(32'hFC00_0000, 1'b1);
        issue(32'hFC00_0000, 1'b0);
        issue(32'h0000_0000, 1'b1);
        issue(32'h3C08_1234, 1'b0);
        issue(32'h0000_0000, 1'b0);
        for (int i = 0; i < 600; i++) issue(gen(), ($urandom_range(0, 40) == 0));
        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
